// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU operation encoding, RV32I opcodes and funct3-to-op decode helpers.
package cpu_pkg;
  typedef enum logic [3:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU
  } operation_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  function automatic operation_t alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_op = alt ? SUB : ADD;
      3'd1:    alu_op = SLL;
      3'd2:    alu_op = SLT;
      3'd3:    alu_op = SLTU;
      3'd4:    alu_op = XOR;
      3'd5:    alu_op = alt ? SRA : SRL;
      3'd6:    alu_op = OR;
      default: alu_op = AND;
    endcase
  endfunction

  // funct3 010/011 have no branch; the decoder flags them separately
  function automatic operation_t br_op(input logic [2:0] f3);
    case (f3)
      3'd0:    br_op = BEQ;
      3'd1:    br_op = BNE;
      3'd4:    br_op = BLT;
      3'd5:    br_op = BGE;
      3'd6:    br_op = BLTU;
      default: br_op = BGEU;
    endcase
  endfunction
endpackage

// File: rtl/cpu_top_alu.sv
// alu: RV32I integer ALU with branch condition flags and a forced-zero error path.
module alu
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  operation_t      op,
  input  logic            err,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            eq_flag,
  output logic            less_flag,
  output logic            err_flag
);
  logic [XLEN-1:0] r;
  logic [4:0]      sh;
  logic            slt, ult;

  assign sh  = b[4:0];
  assign slt = $signed(a) < $signed(b);
  assign ult = a < b;

  always_comb begin
    case (op)
      ADD:     r = a + b;
      SLL:     r = a << sh;
      SLT:     r = {{(XLEN-1){1'b0}}, slt};
      SLTU:    r = {{(XLEN-1){1'b0}}, ult};
      XOR:     r = a ^ b;
      SRL:     r = a >> sh;
      SRA:     r = $unsigned($signed(a) >>> sh);
      OR:      r = a | b;
      AND:     r = a & b;
      default: r = a - b;
    endcase
  end

  assign result    = err ? '0 : r;
  assign zero_flag = result == '0;
  assign err_flag  = err;
  assign eq_flag   = !err && ((op == BEQ && a == b) || (op == BNE && a != b) ||
                              (op == BGE && !slt) || (op == BGEU && !ult));
  assign less_flag = !err && ((op == BLT && slt) || (op == BLTU && ult));
endmodule

// File: rtl/cpu_top.sv
// cpu_top: single-cycle RV32I datapath slice -- decoder, 32x32 register file, ALU,
// with R/I-type results written back on the rising clock edge.
module cpu_top
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] alu_result,
  output logic            zero_flag,
  output logic            eq_flag,
  output logic            less_flag,
  output logic            err_flag,
  output logic            ctrl_err
);
  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] a, b, imm;
  operation_t      op;
  logic            alt, we;

  assign opc = instruction[6:0];
  assign rd  = instruction[11:7];
  assign f3  = instruction[14:12];
  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];
  assign f7  = instruction[31:25];
  assign imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
  assign alt = f7 == 7'b0100000;

  always_comb begin
    op       = ADD;
    ctrl_err = 1'b0;
    case (opc)
      OP_R: begin
        op       = alu_op(f3, alt && (f3 == 3'd0 || f3 == 3'd5));
        ctrl_err = !(f7 == 7'd0 || (alt && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_I: begin
        op       = alu_op(f3, alt && f3 == 3'd5);
        ctrl_err = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && !alt);
      end
      OP_B: begin
        op       = br_op(f3);
        ctrl_err = f3[2:1] == 2'b01;
      end
      default: ctrl_err = 1'b1;
    endcase
  end

  assign a  = rs1 == 5'd0 ? '0 : rf_q[rs1];
  assign b  = opc == OP_I ? imm : (rs2 == 5'd0 ? '0 : rf_q[rs2]);
  assign we = (opc == OP_R || opc == OP_I) && !ctrl_err && rd != 5'd0;

  alu #(.XLEN(XLEN)) u_alu (
    .a        (a),
    .b        (b),
    .op       (op),
    .err      (ctrl_err),
    .result   (alu_result),
    .zero_flag(zero_flag),
    .eq_flag  (eq_flag),
    .less_flag(less_flag),
    .err_flag (err_flag)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    else if (we) rf_q[rd] <= alu_result;
  end
endmodule

// File: tb/tb_cpu_top.sv
// tb_cpu_top: directed instruction vectors with hand-computed results and flags,
// plus async-reset sequences.
module tb_cpu_top;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic [31:0] alu_result;
  logic        zero_flag, eq_flag, less_flag, err_flag, ctrl_err;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  vec_t vecs[$];

  cpu_top dut (
    .clk        (clk),
    .nrst       (nrst),
    .instruction(instruction),
    .alu_result (alu_result),
    .zero_flag  (zero_flag),
    .eq_flag    (eq_flag),
    .less_flag  (less_flag),
    .err_flag   (err_flag),
    .ctrl_err   (ctrl_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic add(input string n, input logic [31:0] i, input logic [31:0] r, input logic [4:0] f);
    vec_t v;
    v.name = n; v.ins = i; v.res = r; v.fl = f;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    instruction = v.ins;
    #1;
    check({v.name, " result"}, alu_result, v.res);
    check({v.name, " flags"}, {27'd0, zero_flag, eq_flag, less_flag, err_flag, ctrl_err}, {27'd0, v.fl});
  endtask

  // flags packed as {zero, eq, less, err, ctrl_err}
  initial begin
    add("slli_reset", 32'h00911313, 32'h0, 5'b10000);
    add("addi_x2_5",  32'h00500113, 32'd5, 5'b00000);
    add("slli_x6",    32'h00911313, 32'd2560, 5'b00000);
    add("add_x7",     32'h000303B3, 32'd2560, 5'b00000);
    add("addi_x1_m1", 32'hFFF00093, 32'hFFFFFFFF, 5'b00000);
    add("srai",       32'h4040D193, 32'hFFFFFFFF, 5'b00000);
    add("srli",       32'h0040D193, 32'h0FFFFFFF, 5'b00000);
    add("sltu",       32'h001031B3, 32'd1, 5'b00000);
    add("slt",        32'h0020A1B3, 32'd1, 5'b00000);
    add("blt",        32'h0020C063, 32'hFFFFFFFA, 5'b00100);
    add("bltu",       32'h0020E063, 32'hFFFFFFFA, 5'b00000);
    add("bge",        32'h00115063, 32'd6, 5'b01000);
    add("beq",        32'h00210063, 32'd0, 5'b11000);
    add("bne_eq",     32'h00211063, 32'd0, 5'b10000);
    add("bgeu",       32'h0020F063, 32'hFFFFFFFA, 5'b01000);
    add("regs_kept",  32'h002081B3, 32'd4, 5'b00000);
    add("sub",        32'h40110233, 32'd6, 5'b00000);
    add("xor",        32'h0020C233, 32'hFFFFFFFA, 5'b00000);
    add("andi",       32'h0F00F213, 32'h000000F0, 5'b00000);
    add("ori_neg",    32'hFF016213, 32'hFFFFFFF5, 5'b00000);
    add("sll",        32'h00211233, 32'd160, 5'b00000);
    add("sra",        32'h4020D233, 32'hFFFFFFFF, 5'b00000);
    add("srl",        32'h0020D233, 32'h07FFFFFF, 5'b00000);
    add("load_opc",   32'h00002103, 32'h0, 5'b10011);
    add("r_f7_1",     32'h02108133, 32'h0, 5'b10011);
    add("b_f3_2",     32'h0020A063, 32'h0, 5'b10011);
    add("slli_f7_20", 32'h40911313, 32'h0, 5'b10011);
    add("x2_kept",    32'h00010213, 32'd5, 5'b00000);
    add("addi_x0_7",  32'h00700013, 32'd7, 5'b00000);
    add("x0_zero",    32'h000002B3, 32'd0, 5'b10000);
    add("x4_is_5",    32'h00010213, 32'd5, 5'b00000);

    repeat (2) @(negedge clk);
    nrst = 1'b1;
    foreach (vecs[k]) apply(vecs[k]);

    // async reset in the middle of a cycle zeroes x2 immediately
    #2;
    nrst = 1'b0;
    #1;
    check("async_rst result", alu_result, 32'h0);
    check("async_rst zero", {31'd0, zero_flag}, 32'd1);

    // a write attempted across an edge while in reset must not land
    @(negedge clk);
    instruction = 32'h00500113;
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    instruction = 32'h00010213;
    #1;
    check("rst_blocks_write", alu_result, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
